montgomery_mul_rk: RTL

- Parametrised successor of the team's bit-serial Montgomery multiplier.
- Computes a*b*2^(-WIDTH) mod N for an odd run-time modulus N.
- Consumes K = RADIX_LOG2 multiplier bits per cycle, with a valid/ready handshake on both input and output.
- Sits in the field-arithmetic datapath (Curve25519 default) between the point-operation sequencer and the register file; the output is held under backpressure.

---
 rtl/mont_pkg.sv | 26 ++
 rtl/mont_digit_step.sv | 28 ++
 rtl/montgomery_mul_rk.sv | 99 +++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared types, constants and helpers for the radix-2^K Montgomery multiplier.
package mont_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;

  // 2^255 - 19
  localparam logic [255:0] CURVE25519_P = {1'b0, {250{1'b1}}, 5'b01101};

  // -N^(-1) mod 2^k; only the low four bits of N matter for k <= 4
  function automatic logic [3:0] n_prime(input logic [3:0] n_low, input int unsigned k);
    logic [3:0] v;
    case (n_low)
      4'd1:    v = 4'd15;
      4'd3:    v = 4'd5;
      4'd5:    v = 4'd3;
      4'd7:    v = 4'd9;
      4'd9:    v = 4'd7;
      4'd11:   v = 4'd13;
      4'd13:   v = 4'd11;
      4'd15:   v = 4'd1;
      default: v = '0;
    endcase
    return v & 4'((1 << k) - 1);
  endfunction

endpackage

// File: rtl/mont_digit_step.sv
// One Montgomery iteration: m_next = (m + d*b + q*N) >> K with q chosen so the low K bits cancel.
module mont_digit_step #(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned RADIX_LOG2 = 1,
  parameter int unsigned ACC_W      = WIDTH + RADIX_LOG2 + 2
) (
  input  logic [WIDTH:0]          i_m,
  input  logic [RADIX_LOG2-1:0]   i_d,
  input  logic [WIDTH-1:0]        i_b,
  input  logic [WIDTH-1:0]        i_n,
  input  logic [RADIX_LOG2-1:0]   i_np,
  output logic [WIDTH:0]          o_m
);

  localparam int unsigned K = RADIX_LOG2;

  logic [ACC_W-1:0] t;
  logic [ACC_W-1:0] s;
  logic [K-1:0]     q;

  always_comb begin
    t   = ACC_W'(i_m) + ACC_W'(i_d) * ACC_W'(i_b);
    q   = t[K-1:0] * i_np;
    s   = t + ACC_W'(q) * ACC_W'(i_n);
    o_m = (WIDTH+1)'(s >> K);
  end

endmodule

// File: rtl/montgomery_mul_rk.sv
// Radix-2^K Montgomery multiplier: a*b*2^(-WIDTH) mod N with valid/ready on both sides.
module montgomery_mul_rk
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned RADIX_LOG2 = 1,
  parameter int unsigned ACC_W      = WIDTH + RADIX_LOG2 + 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam int unsigned K     = RADIX_LOG2;
  localparam int unsigned D     = WIDTH / K;
  localparam int unsigned CNT_W = (D > 1) ? $clog2(D) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [K-1:0]     np_q;
  logic [WIDTH:0]   m_q, m_next;
  logic [CNT_W-1:0] cnt_q;
  logic             last_digit;

  assign last_digit = (cnt_q == CNT_W'(D - 1));

  mont_digit_step #(
    .WIDTH      (WIDTH),
    .RADIX_LOG2 (RADIX_LOG2),
    .ACC_W      (ACC_W)
  ) u_step (
    .i_m  (m_q),
    .i_d  (a_q[K-1:0]),
    .i_b  (b_q),
    .i_n  (n_q),
    .i_np (np_q),
    .o_m  (m_next)
  );

  always_comb begin
    state_d    = state_q;
    o_in_ready = (state_q == IDLE);
    o_busy     = (state_q == CALC) || (state_q == FINAL);
    unique case (state_q)
      IDLE:    if (i_in_valid) state_d = CALC;
      CALC:    if (last_digit) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (i_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // a is shifted down each iteration so the current digit always sits in the low K bits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      n_q         <= '0;
      np_q        <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      o_result    <= '0;
      o_out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (i_in_valid) begin
          a_q   <= i_a;
          b_q   <= i_b;
          n_q   <= i_n;
          np_q  <= K'(n_prime(i_n[3:0], K));
          m_q   <= '0;
          cnt_q <= '0;
        end
        CALC: begin
          m_q   <= m_next;
          a_q   <= a_q >> K;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FINAL: begin
          o_result    <= (m_q >= {1'b0, n_q}) ? WIDTH'(m_q - {1'b0, n_q}) : m_q[WIDTH-1:0];
          o_out_valid <= 1'b1;
        end
        DONE: if (i_out_ready) o_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
